npu_output_interface: RTL
=========================

Name: npu_output_interface

Overview:
Output-side counterpart of the NPU input interface. Accepts 16-bit fixed-point results from the scheduler/sigmoid path and converts them to 32-bit words according to a configured output format. Buffers the words in an output FIFO that the host drains through npu_output_data, npu_output_fifo_empty and a read enable. Sits between npu_state_machine/npu_scheduler (write side) and the NPU top-level output ports (read side).

Parameters:
DEPTH, 16, output FIFO depth in 32-bit words; must be a power of two.
ADDR_W, 4, log2(DEPTH).

Ports:
CLK  in  1  clock; all logic rising-edge.
RST  in  1  reset, asynchronous, active-high.
npu_rst  in  1  synchronous soft reset from the config interface.
npu_output_fifo_write_en  in  1  result-valid strobe from the state machine.
npu_output_interface_data_in  in  16  result value, signed Q format.
npu_output_flush  in  1  pulse that pushes a pending packed half-word.
npu_output_format_write_en  in  1  load the format register.
npu_output_interface_conf_data  in  16  format word; [1:0]=mode, [6:2]=shift.
npu_output_fifo_read_en  in  1  host read strobe.
npu_output_data  out  32  registered FIFO head.
npu_output_fifo_empty  out  1  FIFO holds no words.
npu_output_fifo_full  out  1  FIFO holds DEPTH words.
npu_output_fifo_count  out  ADDR_W+1  current occupancy.
npu_output_overflow  out  1  sticky: a word was dropped.

Behaviour:
- RST asserted: npu_output_data=0, empty=1, full=0, count=0, overflow=0, format=0, pack state IDLE, pointers 0.
- npu_rst: same clear on the next edge, except the format register is retained.
- Format load: takes effect on the next edge. A load while the pack state is HALF discards the pending half.
- Mode 0, sign-extend: word = {{16{d[15]}}, d}.
- Mode 1, zero-extend: word = {16'h0, d}.
- Mode 2, shift: word = sign-extend(d) << shift (0..31), truncated to 32 bits.
- Mode 3, pack: two-state FSM.
  - IDLE + write: latch d as the low half, go to HALF; nothing is pushed.
  - HALF + write: push {d, low}, go to IDLE.
  - HALF + flush: push {16'h0, low}, go to IDLE.
  - IDLE + flush: no effect.
  - Write and flush in the same cycle: the write takes priority and the flush is ignored.
- Modes 0-2 push one word per write strobe; flush has no effect.
- Push timing: the converted word is written to FIFO memory on the same edge as the strobe. count increments at that edge, so empty drops the cycle after the first push.
- Read: read_en && !empty loads the head into npu_output_data at the edge and advances the read pointer; data is valid in the cycle after read_en.
- read_en while empty is ignored and npu_output_data holds its value.
- Push while full (count==DEPTH): word dropped, overflow set. overflow stays set until RST or npu_rst.
- Simultaneous push and read:
  - Not full and not empty: both accepted, count unchanged.
  - Full: read accepted, push dropped, overflow set.
  - Empty: push accepted, read ignored.
- Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).

Optional Feature:
NPU_OUTPUT_SATURATE_EN
- Defined: in mode 2, if the shifted value exceeds the signed 32-bit range, the word clamps to 32'h7FFFFFFF (positive) or 32'h80000000 (negative).
- Undefined: mode 2 truncates to the low 32 bits and wraps.
- Other modes are unaffected either way.

Test Plan:
- Mode 0: write 16'hFF80 then 16'h0042, read twice -> 32'hFFFFFF80, then 32'h00000042; empty=1 afterwards.
- Mode 3: writes 16'h1111, 16'h2222, 16'h3333, then flush -> FIFO holds 32'h22221111, 32'h00003333; count=2.
- Fill DEPTH=16 words, then one more write -> full=1, overflow=1, extra word absent; 16 reads return the original order.
- Full FIFO with simultaneous read+write -> head returned, count=15, overflow=1. Empty FIFO with simultaneous read+write -> count=1, npu_output_data unchanged.
- Mode 2, shift=20, input 16'h4000:
  - With NPU_OUTPUT_SATURATE_EN -> 32'h7FFFFFFF.
  - Without -> 32'h00000000.
  - Shift=4, input 16'hFFFF -> 32'hFFFFFFF0 in both builds.
- RST asserted asynchronously mid-fill with count=5 and pack state HALF -> outputs immediately reset values; the next mode-0 write after release yields count=1.

Source files
------------

// File: rtl/npu_output_interface.sv
// NPU output interface: converts 16-bit results to 32-bit words (sign/zero/shift/pack) into a host-drained FIFO.
// Optional macro NPU_OUTPUT_SATURATE_EN clamps shift-mode results to the signed 32-bit range instead of wrapping.
module npu_output_interface #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              npu_rst,
  input  logic              npu_output_fifo_write_en,
  input  logic [15:0]       npu_output_interface_data_in,
  input  logic              npu_output_flush,
  input  logic              npu_output_format_write_en,
  input  logic [15:0]       npu_output_interface_conf_data,
  input  logic              npu_output_fifo_read_en,
  output logic [31:0]       npu_output_data,
  output logic              npu_output_fifo_empty,
  output logic              npu_output_fifo_full,
  output logic [ADDR_W:0]   npu_output_fifo_count,
  output logic              npu_output_overflow
);

  typedef enum logic [1:0] {MODE_SEXT, MODE_ZEXT, MODE_SHIFT, MODE_PACK} mode_e;
  typedef enum logic {ST_IDLE, ST_HALF} pack_state_e;

  mode_e             mode_q;
  logic [4:0]        shift_q;
  pack_state_e       pack_q, pack_d;
  logic [15:0]       low_q, low_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       data_q;
  logic              overflow_q;
  logic [31:0]       mem [DEPTH];

  logic              push_req, push_acc, rd_acc, full, empty;
  logic [31:0]       push_word, shift_word;
  logic [15:0]       din;
  logic              unused_conf;

  assign din         = npu_output_interface_data_in;
  assign unused_conf = ^npu_output_interface_conf_data[15:7];
  assign full        = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty       = (count_q == '0);

`ifdef NPU_OUTPUT_SATURATE_EN
  // 16-bit input shifted by up to 31 fits a 48-bit signed value; overflow if bits [47:31] disagree.
  logic [47:0] shifted;
  always_comb begin
    shifted = {{32{din[15]}}, din} << shift_q;
    if (shifted[47:31] != {17{shifted[47]}})
      shift_word = shifted[47] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      shift_word = shifted[31:0];
  end
`else
  always_comb shift_word = {{16{din[15]}}, din} << shift_q;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    push_req  = 1'b0;
    push_word = '0;
    pack_d    = pack_q;
    low_d     = low_q;
    case (mode_q)
      MODE_SEXT: begin
        push_req  = npu_output_fifo_write_en;
        push_word = {{16{din[15]}}, din};
      end
      MODE_ZEXT: begin
        push_req  = npu_output_fifo_write_en;
        push_word = {16'h0, din};
      end
      MODE_SHIFT: begin
        push_req  = npu_output_fifo_write_en;
        push_word = shift_word;
      end
      MODE_PACK: begin
        if (npu_output_fifo_write_en) begin
          if (pack_q == ST_IDLE) begin
            low_d  = din;
            pack_d = ST_HALF;
          end else begin
            push_req  = 1'b1;
            push_word = {din, low_q};
            pack_d    = ST_IDLE;
          end
        end else if (npu_output_flush && pack_q == ST_HALF) begin
          push_req  = 1'b1;
          push_word = {16'h0, low_q};
          pack_d    = ST_IDLE;
        end
      end
      default: ;
    endcase
    // A format reload abandons any half-assembled pack word.
    if (npu_output_format_write_en) pack_d = ST_IDLE;
  end

  // A push into a full FIFO is dropped even if a read frees a slot on the same edge.
  assign push_acc = push_req && !full;
  assign rd_acc   = npu_output_fifo_read_en && !empty;
  assign count_d  = count_q + (ADDR_W+1)'(push_acc) - (ADDR_W+1)'(rd_acc);

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q     <= MODE_SEXT;
      shift_q    <= '0;
      pack_q     <= ST_IDLE;
      low_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else if (npu_rst) begin
      pack_q     <= ST_IDLE;
      low_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (npu_output_format_write_en) begin
        mode_q  <= mode_e'(npu_output_interface_conf_data[1:0]);
        shift_q <= npu_output_interface_conf_data[6:2];
      end
      pack_q  <= pack_d;
      low_q   <= low_d;
      count_q <= count_d;
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_q   <= mem[rd_ptr_q];
      end
      if (push_req && full) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push_acc) mem[wr_ptr_q] <= push_word;
  end

  assign npu_output_data       = data_q;
  assign npu_output_fifo_empty = empty;
  assign npu_output_fifo_full  = full;
  assign npu_output_fifo_count = count_q;
  assign npu_output_overflow   = overflow_q;

endmodule
